// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Buffers signed samples from a valid/ready source in a small circular FIFO
//   and issues them one at a time to a 16-tap FIR that has no backpressure.
//   Each issue is a registered data word on fir_in plus a one-cycle pulse on
//   fir_input_ready. Consecutive pulses are at least GAP cycles apart, so the
//   FIR (busy 19 cycles per sample) never sees a sample mid-computation.
//
// Ports
//   ck               clock, all logic on the rising edge
//   rst              synchronous reset, active-high
//   s_data           signed source sample
//   s_valid          source sample valid
//   s_ready          FIFO not full; a push happens when s_valid && s_ready
//   run              issue enable; low blocks new issues (never cancels one)
//   fir_in           registered sample to the FIR, held between issues
//   fir_input_ready  registered one-cycle issue pulse
//   level            registered FIFO occupancy, 0..DEPTH
//   dbg_state_o      issue FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: the source may change s_data/s_valid freely; a sample is taken
// on a rising edge where s_valid && s_ready and rst is low. s_ready depends
// only on registered pointers, never on s_valid or on a same-cycle pop.

module fir_sample_feeder #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int GAP   = 20
) (
   input  logic                       ck,
   input  logic                       rst,
   input  logic signed [WIDTH-1:0]    s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic                       run,
   output logic signed [WIDTH-1:0]    fir_in,
   output logic                       fir_input_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       dbg_state_o
);

   localparam int AW = $clog2(DEPTH);   // address bits
   localparam int PW = AW + 1;          // pointer bits, MSB is the lap bit
   localparam int CW = $clog2(GAP);     // holds GAP-1

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [PW-1:0]            wptr_q, wptr_d;
   logic [PW-1:0]            rptr_q, rptr_d;
   logic [PW-1:0]            level_q, level_d;
   logic signed [WIDTH-1:0]  fir_in_q, fir_in_d;
   logic                     pulse_q, pulse_d;
   logic [WIDTH-1:0]         mem_q [DEPTH];

   logic full, empty, push, pop;

   // Same address on different laps means the writer is a full lap ahead.
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign push  = s_valid && !full;

   assign s_ready         = !full;
   assign fir_in          = fir_in_q;
   assign fir_input_ready = pulse_q;
   assign level           = level_q;
   assign dbg_state_o     = state_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fir_in_d = fir_in_q;
      pulse_d  = 1'b0;
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (run && !empty) begin
               pop      = 1'b1;
               fir_in_d = mem_q[rptr_q[AW-1:0]];
               pulse_d  = 1'b1;
               cnt_d    = CW'(GAP - 1);
               state_d  = HOLD;
            end
         end
         HOLD: begin
            // GAP-1 HOLD edges follow the issue edge, so the next issue edge
            // lands exactly GAP edges after this one.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      wptr_d  = wptr_q + PW'(push);
      rptr_d  = rptr_q + PW'(pop);
      level_d = level_q + PW'(push) - PW'(pop);
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         fir_in_q <= '0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         fir_in_q <= fir_in_d;
         pulse_q  <= pulse_d;
      end
   end

   // Storage needs no reset; pointers define what is valid.
   always_ff @(posedge ck) begin
      if (!rst && push) begin
         mem_q[wptr_q[AW-1:0]] <= s_data;
      end
   end

   // Parameter sanity: the FIR needs 19 busy cycles, and the pointer scheme
   // needs a power-of-two depth.
   always_ff @(posedge ck) begin
      if (!rst) begin
         assert (GAP >= 19 && DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
      end
   end

endmodule
